// File: rtl/gpio_reg_arbiter_if.sv
// gpio_reg_arbiter_if: one requester port of the GPIO register arbiter.
// Signals: req, addr[4:2], wben, r_wn, wdata (master->arbiter); ack, rdata (arbiter->master).
interface gpio_reg_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic              req;
    logic [4:2]        addr;
    logic [STRB_W-1:0] wben;
    logic              r_wn;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, addr, wben, r_wn, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, wben, r_wn, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/gpio_reg_arbiter.sv
// gpio_reg_arbiter: two-port arbiter/sequencer in front of the GPIO register file.
// Ports: clk, reset (async, active-high); m0/m1 requester interfaces (slave side);
//   rf_addr/rf_wben/rf_r_wn/rf_wdata out and rf_rdata in to the register file;
//   busy (FSM not idle), grant_id (owner of current/last transaction).
// Build option GPIO_ARB_RR_EN: round-robin arbitration; otherwise port 0 has fixed priority.
module gpio_reg_arbiter #(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    gpio_reg_arbiter_if.slave m0,
    gpio_reg_arbiter_if.slave m1,
    output logic [4:2]        rf_addr,
    output logic [STRB_W-1:0] rf_wben,
    output logic              rf_r_wn,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:2]        addr_d;
    logic [STRB_W-1:0] wben_d;
    logic              r_wn_d;
    logic [DATA_W-1:0] wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_d;
    logic              grant_d;
    logic              both;
    logic              pref;
    logic              win;

`ifdef GPIO_ARB_RR_EN
    // Port preferred on a tie: the one not granted last time.
    logic rr_q, rr_d;
    assign pref = rr_q;
`else
    assign pref = 1'b0;
`endif

    // A lone request always wins; a tie goes to the preferred port.
    assign both = m0.req & m1.req;
    assign win  = both ? pref : m1.req;

    assign m0.ack   = ack0_q;
    assign m1.ack   = ack1_q;
    assign m0.rdata = rdata0_q;
    assign m1.rdata = rdata1_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = rf_addr;
        wben_d   = rf_wben;
        r_wn_d   = rf_r_wn;
        wdata_d  = rf_wdata;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_d  = grant_id;
`ifdef GPIO_ARB_RR_EN
        rr_d     = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    state_d = ACCESS;
                    grant_d = win;
                    addr_d  = win ? m1.addr  : m0.addr;
                    wben_d  = win ? m1.wben  : m0.wben;
                    r_wn_d  = win ? m1.r_wn  : m0.r_wn;
                    wdata_d = win ? m1.wdata : m0.wdata;
`ifdef GPIO_ARB_RR_EN
                    rr_d    = ~win;
`endif
                end
            end
            ACCESS: begin
                // Register file commits on this closing edge; bus goes idle.
                state_d = CAPTURE;
                wben_d  = '0;
                r_wn_d  = 1'b1;
            end
            CAPTURE: begin
                // rf_rdata now holds the registered post-access word.
                state_d = DONE;
                if (grant_id) begin
                    rdata1_d = rf_rdata;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = rf_rdata;
                    ack0_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rf_addr  <= '0;
            rf_wben  <= '0;
            rf_r_wn  <= 1'b1;
            rf_wdata <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            state_q  <= state_d;
            rf_addr  <= addr_d;
            rf_wben  <= wben_d;
            rf_r_wn  <= r_wn_d;
            rf_wdata <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy     <= busy_d;
            grant_id <= grant_d;
        end
    end

`ifdef GPIO_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule
